// File: rtl/uart_rx_buffered_pkg.sv
// Shared types for the buffered UART receiver: FSM state encoding, data width, parity helper.
// Optional feature macro used by the users of this package: UART_PARITY_EN.
package uart_rx_buffered_pkg;

  typedef enum logic [2:0] {IDLE_S, START_S, DATA_S, PARITY_S, STOP_S} uart_rxb_state_t;

  localparam int UART_DATA_W = 8;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; reports a push refused because the FIFO is full.
// A push coinciding with a pop on a full FIFO is accepted (the pop frees the slot).
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              accept,
  output logic              overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_pop   = pop && !empty;
  assign accept  = push && (!full || w_pop);
  assign overrun = push && !accept;
  assign dout    = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; emptiness masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (accept) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (8 data bits, LSB first, 1 stop) feeding a FWFT FIFO, with sticky error flags.
// Define UART_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rx_valid,
  output logic                   rx_full,
  output logic                   rx_done,
  output logic                   framing_error,
  output logic                   overrun_error,
  output logic                   parity_error,
  output uart_rxb_state_t        rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                   r_sync1, r_sync2;
  uart_rxb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_bad, w_bad_nxt;
  logic                   r_done, r_ferr, r_oerr;
  logic                   w_rx, w_shift_en, w_push, w_ferr_set, w_perr_set;
  logic                   w_accept, w_overrun, w_empty;

  assign w_rx = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_bad_nxt   = r_bad;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
    case (r_state)
      IDLE_S: begin
        w_cnt_nxt = '0;
        if (!w_rx) begin
          w_state_nxt = START_S;
          w_bit_nxt   = '0;
          w_bad_nxt   = 1'b0;
        end
      end
      START_S: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? IDLE_S : DATA_S;
        end
      end
      DATA_S: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          w_bit_nxt  = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_nxt = PARITY_S;
`else
            w_state_nxt = STOP_S;
`endif
          end
        end
      end
      PARITY_S: begin
`ifdef UART_PARITY_EN
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_bad_nxt   = (w_rx != even_parity(r_shift));
          w_state_nxt = STOP_S;
        end
`else
        w_state_nxt = IDLE_S;
`endif
      end
      STOP_S: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE_S;
          w_ferr_set  = !w_rx;
          w_perr_set  = r_bad;
          w_push      = w_rx && !r_bad;
        end
      end
      default: w_state_nxt = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE_S;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_bad   <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_bad   <= w_bad_nxt;
      r_done  <= w_accept;
      // A fresh error outranks a simultaneous clear.
      r_ferr  <= w_ferr_set | (r_ferr & ~err_clr);
      r_oerr  <= w_overrun  | (r_oerr & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {w_rx, r_shift[UART_DATA_W-1:1]};
  end

`ifdef UART_PARITY_EN
  logic r_perr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_perr_set | (r_perr & ~err_clr);
  end
  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

  uart_rx_fifo #(
    .DATA_W(UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .din    (r_shift),
    .pop    (rd_en),
    .dout   (rd_data),
    .full   (rx_full),
    .empty  (w_empty),
    .accept (w_accept),
    .overrun(w_overrun)
  );

  assign rx_valid      = !w_empty;
  assign rx_done       = r_done;
  assign framing_error = r_ferr;
  assign overrun_error = r_oerr;
  assign rx_state      = r_state;

  logic w_unused;
  assign w_unused = w_perr_set;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized bench for uart_rx_buffered: frames on rx compared against a queue-based receiver model.
// Build with UART_PARITY_EN defined to exercise the parity frame format.
module tb_uart_rx_buffered;
  import uart_rx_buffered_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic rx_valid, rx_full, rx_done, framing_error, overrun_error, parity_error;
  uart_rxb_state_t rx_state;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full), .rx_done(rx_done),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .parity_error(parity_error), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;
  int done_cnt = 0, start_cnt = 0, exp_done = 0;
  logic [7:0] q[$];
  bit e_ferr = 0, e_oerr = 0, e_perr = 0;

  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (rx_state == START_S) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input logic parb);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    if (PAR_EN) begin rx = parb; tick(CPB); end
    rx = stopb; tick(CPB);
    rx = 1'b1;
  endtask

  // Receiver model: a frame is either dropped with its error flags, refused as overrun, or queued.
  task automatic frame(input logic [7:0] b, input logic stopb, input logic badpar);
    bit par_bad;
    par_bad = PAR_EN && badpar;
    send_frame(b, stopb, (^b) ^ badpar);
    if (!stopb) e_ferr = 1'b1;
    if (par_bad) e_perr = 1'b1;
    if (stopb && !par_bad) begin
      if (q.size() == DEPTH) e_oerr = 1'b1;
      else begin q.push_back(b); exp_done++; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(rx_valid), 32'(q.size() != 0));
    chk({tag, ".full"},  32'(rx_full),  32'(q.size() == DEPTH));
    chk({tag, ".data"},  32'(rd_data),  32'(q.size() != 0 ? q[0] : 8'h00));
    chk({tag, ".ferr"},  32'(framing_error), 32'(e_ferr));
    chk({tag, ".oerr"},  32'(overrun_error), 32'(e_oerr));
    chk({tag, ".perr"},  32'(parity_error),  32'(e_perr));
    chk({tag, ".done"},  32'(done_cnt), 32'(exp_done));
    chk({tag, ".state"}, 32'(rx_state), 32'(IDLE_S));
  endtask

  task automatic pop();
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    e_ferr = 1'b0; e_oerr = 1'b0; e_perr = 1'b0;
  endtask

  task automatic test_single(input string tag);
    frame(8'h0C, 1'b1, 1'b0); tick(4);
    check_all(tag);
    chk({tag, ".byte"}, 32'(rd_data), 32'h0C);
    pop(); tick(1);
    check_all({tag, ".pop"});
  endtask

  initial begin
    int sc;
    tick(3);
    check_all("reset");
    rst = 1'b1; tick(2);

    test_single("t1");

    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0);
    tick(4);
    check_all("t2");
    chk("t2.full_abs", 32'(rx_full), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2.pop", 32'(rd_data), 32'(i));
      pop();
    end
    tick(1);
    check_all("t2.empty");
    clr(); tick(1);

    frame(8'hA5, 1'b0, 1'b0); tick(4);
    check_all("t3");
    clr(); tick(1);
    check_all("t3.clr");

    sc = start_cnt;
    rx = 1'b0; tick(4); rx = 1'b1; tick(2 * CPB);
    check_all("t4");
    chk("t4.saw_start", 32'(start_cnt > sc), 32'h1);

    if (PAR_EN) begin
      frame(8'h0C, 1'b1, 1'b1); tick(4);
      check_all("t5.bad");
      frame(8'h0C, 1'b1, 1'b0); tick(4);
      check_all("t5.good");
      pop(); clr(); tick(1);
    end

    frame(8'h33, 1'b0, 1'b0);
    frame(8'h11, 1'b1, 1'b0);
    frame(8'h22, 1'b1, 1'b0);
    tick(4);
    check_all("t6.pre");
    rx = 1'b0; tick(CPB); rx = 1'b1; tick(CPB + CPB / 2);
    chk("t6.in_data", 32'(rx_state), 32'(DATA_S));
    rst = 1'b0; #1;
    q.delete(); e_ferr = 1'b0; e_oerr = 1'b0; e_perr = 1'b0;
    check_all("t6.rst");
    rx = 1'b1; tick(3);
    rst = 1'b1; tick(2);
    test_single("t6.after");

    for (int it = 0; it < 30; it++) begin
      logic [7:0] b;
      b = 8'($urandom);
      frame(b, $urandom_range(0, 7) != 0, PAR_EN && ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) != 0) begin
        tick(4);
        check_all("rnd");
        repeat ($urandom_range(0, 2)) begin
          chk("rnd.head", 32'(rd_data), 32'(q.size() != 0 ? q[0] : 8'h00));
          pop();
        end
        if ($urandom_range(0, 3) == 0) clr();
        tick(1);
        check_all("rnd.post");
      end
    end
    tick(4);
    check_all("rnd.end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
